// File: rtl/ff_table_pkg.sv
// Shared constants and types for the first-filter match table and its loader.
package ff_table_pkg;

  localparam int FF_TBL_AWIDTH = 13;
  localparam int FF_TBL_DWIDTH = 64;
  localparam int FF_TBL_SIZE   = 8192;
  localparam logic [FF_TBL_DWIDTH-1:0] FF_TBL_CLR = '1;

  typedef enum logic {
    CFG_ADDR = 1'b0,
    CFG_DATA = 1'b1
  } cfg_sel_t;

  typedef enum logic {
    LD_IDLE,
    LD_CLEAR
  } loader_state_t;

endpackage

// File: rtl/first_filter_table_loader_if.sv
// Config stream, clear control and table write port of the first-filter table loader.
interface first_filter_table_loader_if
  import ff_table_pkg::*;
#(
  parameter int AWIDTH = FF_TBL_AWIDTH
);

  logic                     clr_start;
  logic                     cfg_valid;
  logic                     cfg_ready;
  cfg_sel_t                 cfg_sel;
  logic [31:0]              cfg_data;
  logic [FF_TBL_DWIDTH-1:0] wr_data;
  logic [AWIDTH-1:0]        wr_addr;
  logic                     wr_en;
  logic                     busy;
  logic                     done;
  logic [15:0]              wr_count;
  logic [FF_TBL_DWIDTH-1:0] checksum;

  // Host / CSR side.
  modport master (
    output clr_start, cfg_valid, cfg_sel, cfg_data,
    input  cfg_ready, wr_data, wr_addr, wr_en, busy, done, wr_count, checksum
  );

  // Loader side.
  modport slave (
    input  clr_start, cfg_valid, cfg_sel, cfg_data,
    output cfg_ready, wr_data, wr_addr, wr_en, busy, done, wr_count, checksum
  );

endinterface

// File: rtl/first_filter_table_loader.sv
// Turns 32-bit config beats into 64-bit match-table writes and runs a bulk table clear.
// Optional macro FF_LOADER_CHECKSUM_EN adds an XOR checksum over data-beat writes.
module first_filter_table_loader
  import ff_table_pkg::*;
#(
  parameter int                       AWIDTH    = FF_TBL_AWIDTH,
  parameter int                       MEM_SIZE  = FF_TBL_SIZE,
  parameter logic [FF_TBL_DWIDTH-1:0] CLR_VALUE = FF_TBL_CLR
) (
  input  logic                        clk,
  input  logic                        rst,
  first_filter_table_loader_if.slave  bus
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  // Folds an out-of-range start address back into the table.
  function automatic logic [AWIDTH-1:0] fold_addr(input logic [AWIDTH-1:0] a);
    if ({1'b0, a} >= (AWIDTH + 1)'(MEM_SIZE)) return a - AWIDTH'(MEM_SIZE);
    return a;
  endfunction

  loader_state_t             r_state;
  loader_state_t             w_state_next;

  logic [AWIDTH-1:0]         r_ptr,       w_ptr_next;
  logic [31:0]               r_lo,        w_lo_next;
  logic                      r_pending,   w_pending_next;
  logic                      r_wr_en,     w_wr_en_next;
  logic [AWIDTH-1:0]         r_wr_addr,   w_wr_addr_next;
  logic [FF_TBL_DWIDTH-1:0]  r_wr_data,   w_wr_data_next;
  logic                      r_busy,      w_busy_next;
  logic                      r_done,      w_done_next;
  logic [15:0]               r_wr_count,  w_wr_count_next;
  logic                      w_cfg_ready;

  logic w_beat, w_addr_beat, w_data_beat, w_entry_done, w_clr_last;

  // A clear request wins over a config beat presented in the same cycle.
  assign w_beat       = bus.cfg_valid && (r_state == LD_IDLE) && !bus.clr_start;
  assign w_addr_beat  = w_beat && (bus.cfg_sel == CFG_ADDR);
  assign w_data_beat  = w_beat && (bus.cfg_sel == CFG_DATA);
  assign w_entry_done = w_data_beat && r_pending;
  assign w_clr_last   = (r_state == LD_CLEAR) && (r_wr_addr == LAST_ADDR);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= LD_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      LD_IDLE:  if (bus.clr_start) w_state_next = LD_CLEAR;
      LD_CLEAR: if (w_clr_last)    w_state_next = LD_IDLE;
      default:                     w_state_next = LD_IDLE;
    endcase
  end

  // NOTE: every output of this block gets a default first; without it a
  // missed branch would infer a latch instead of holding the register.
  always_comb begin
    w_cfg_ready     = (r_state == LD_IDLE);
    w_ptr_next      = r_ptr;
    w_lo_next       = r_lo;
    w_pending_next  = r_pending;
    w_wr_en_next    = 1'b0;
    w_wr_addr_next  = r_wr_addr;
    w_wr_data_next  = r_wr_data;
    w_busy_next     = 1'b0;
    w_done_next     = 1'b0;
    w_wr_count_next = r_wr_count;
    unique case (r_state)
      LD_IDLE: begin
        if (bus.clr_start) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = '0;
          w_wr_data_next = CLR_VALUE;
          w_busy_next    = 1'b1;
          w_pending_next = 1'b0;
        end else if (w_addr_beat) begin
          w_ptr_next     = fold_addr(bus.cfg_data[AWIDTH-1:0]);
          w_pending_next = 1'b0;
        end else if (w_data_beat && !r_pending) begin
          w_lo_next      = bus.cfg_data;
          w_pending_next = 1'b1;
        end else if (w_entry_done) begin
          w_wr_en_next    = 1'b1;
          w_wr_addr_next  = r_ptr;
          w_wr_data_next  = {bus.cfg_data, r_lo};
          w_ptr_next      = (r_ptr == LAST_ADDR) ? '0 : r_ptr + AWIDTH'(1);
          w_pending_next  = 1'b0;
          w_wr_count_next = (r_wr_count == 16'hFFFF) ? r_wr_count : r_wr_count + 16'd1;
        end
      end
      LD_CLEAR: begin
        if (w_clr_last) begin
          w_done_next     = 1'b1;
          w_ptr_next      = '0;
          w_wr_count_next = '0;
        end else begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_wr_addr + AWIDTH'(1);
          w_busy_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_lo       <= '0;
      r_pending  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_ptr      <= w_ptr_next;
      r_lo       <= w_lo_next;
      r_pending  <= w_pending_next;
      r_wr_en    <= w_wr_en_next;
      r_wr_addr  <= w_wr_addr_next;
      r_wr_data  <= w_wr_data_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_wr_count <= w_wr_count_next;
    end
  end

`ifdef FF_LOADER_CHECKSUM_EN
  logic [FF_TBL_DWIDTH-1:0] r_checksum;

  // Updated on the same edge that presents the write, so it always covers wr_data.
  always_ff @(posedge clk) begin
    if (rst || w_clr_last) r_checksum <= '0;
    else if (w_entry_done) r_checksum <= r_checksum ^ w_wr_data_next;
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_first_filter_table_loader.sv
// Directed bench for first_filter_table_loader: clear, address/data beats, wrap, checksum, reset abort.
module tb_first_filter_table_loader;
  import ff_table_pkg::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  first_filter_table_loader_if #(.AWIDTH(13)) ifc ();

  first_filter_table_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input cfg_sel_t sel, input logic [31:0] d);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_sel   = sel;
    ifc.cfg_data  = d;
    step();
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.clr_start = 1'b0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_sel   = CFG_ADDR;
    ifc.cfg_data  = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic pulse_clear();
    ifc.clr_start = 1'b1;
    step();
    ifc.clr_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (ifc.done !== 1'b1 && n < 9000) begin
      step();
      n++;
    end
    total++;
    if (ifc.done !== 1'b1) begin
      bad++;
      $display("FAIL %s_done_timeout got=%b want=1", tag, ifc.done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ifc.wr_en, ifc.busy, ifc.done, ifc.cfg_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0001", {ifc.wr_en, ifc.busy, ifc.done, ifc.cfg_ready});
    end
    total++;
    if (ifc.wr_data !== 64'd0 || ifc.wr_addr !== 13'd0 || ifc.wr_count !== 16'd0 || ifc.checksum !== 64'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h/%h/%h want=0", ifc.wr_data, ifc.wr_addr, ifc.wr_count, ifc.checksum);
    end
  endtask

  task automatic test_clear();
    int errs = 0;
    int first = -1;
    pulse_clear();
    for (int i = 0; i < 8192; i++) begin
      if (i == 100) ifc.clr_start = 1'b1;
      if (i == 101) ifc.clr_start = 1'b0;
      if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'(i) || ifc.wr_data !== 64'hFFFF_FFFF_FFFF_FFFF ||
          ifc.cfg_ready !== 1'b0 || ifc.busy !== 1'b1 || ifc.done !== 1'b0) begin
        errs++;
        if (first < 0) first = i;
      end
      step();
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL clear_seq got=%0d bad cycles (first at %0d, addr=%h en=%b) want=0", errs, first, ifc.wr_addr, ifc.wr_en);
    end
    total++;
    if ({ifc.done, ifc.busy, ifc.wr_en, ifc.cfg_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL clear_end got=%b want=1001", {ifc.done, ifc.busy, ifc.wr_en, ifc.cfg_ready});
    end
    step();
    total++;
    if (ifc.done !== 1'b0) begin
      bad++;
      $display("FAIL clear_done_pulse got=%b want=0", ifc.done);
    end
  endtask

  task automatic test_basic_write();
    beat(CFG_ADDR, 32'h0000_0100);
    beat(CFG_DATA, 32'hDEAD_BEEF);
    total++;
    if (ifc.wr_en !== 1'b0) begin
      bad++;
      $display("FAIL basic_half_no_write got=%b want=0", ifc.wr_en);
    end
    beat(CFG_DATA, 32'h0123_4567);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h100 || ifc.wr_data !== 64'h0123_4567_DEAD_BEEF) begin
      bad++;
      $display("FAIL basic_write got=%b/%h/%h want=1/0100/0123_4567_DEAD_BEEF", ifc.wr_en, ifc.wr_addr, ifc.wr_data);
    end
    beat(CFG_DATA, 32'h1111_1111);
    beat(CFG_DATA, 32'h2222_2222);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h101 || ifc.wr_data !== 64'h2222_2222_1111_1111) begin
      bad++;
      $display("FAIL basic_incr got=%b/%h/%h want=1/0101/2222_2222_1111_1111", ifc.wr_en, ifc.wr_addr, ifc.wr_data);
    end
    step();
    total++;
    if (ifc.wr_en !== 1'b0 || ifc.wr_addr !== 13'h101 || ifc.wr_data !== 64'h2222_2222_1111_1111 || ifc.wr_count !== 16'd2) begin
      bad++;
      $display("FAIL basic_hold got=%b/%h/%h/%0d want=0/0101/2222_2222_1111_1111/2", ifc.wr_en, ifc.wr_addr, ifc.wr_data, ifc.wr_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    beat(CFG_ADDR, 32'h0000_1FFF);
    beat(CFG_DATA, 32'h11);
    beat(CFG_DATA, 32'h22);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h1FFF) begin
      bad++;
      $display("FAIL wrap_last got=%b/%h want=1/1fff", ifc.wr_en, ifc.wr_addr);
    end
    beat(CFG_DATA, 32'h33);
    beat(CFG_DATA, 32'h44);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h0000 || ifc.wr_data !== 64'h0000_0044_0000_0033) begin
      bad++;
      $display("FAIL wrap_zero got=%b/%h/%h want=1/0000/0000_0044_0000_0033", ifc.wr_en, ifc.wr_addr, ifc.wr_data);
    end
    total++;
    if (ifc.wr_count !== 16'd2) begin
      bad++;
      $display("FAIL wrap_count got=%0d want=2", ifc.wr_count);
    end
    beat(CFG_ADDR, 32'h0000_2005);
    beat(CFG_DATA, 32'h55);
    beat(CFG_DATA, 32'h66);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h0005) begin
      bad++;
      $display("FAIL addr_modulo got=%b/%h want=1/0005", ifc.wr_en, ifc.wr_addr);
    end
  endtask

  task automatic test_stale_half();
    beat(CFG_DATA, 32'hAAAA_AAAA);
    beat(CFG_ADDR, 32'h0000_0020);
    beat(CFG_DATA, 32'h0000_0001);
    total++;
    if (ifc.wr_en !== 1'b0) begin
      bad++;
      $display("FAIL stale_no_write got=%b want=0", ifc.wr_en);
    end
    beat(CFG_DATA, 32'h0000_0002);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h0020 || ifc.wr_data !== 64'h0000_0002_0000_0001) begin
      bad++;
      $display("FAIL stale_write got=%b/%h/%h want=1/0020/0000_0002_0000_0001", ifc.wr_en, ifc.wr_addr, ifc.wr_data);
    end
  endtask

  task automatic test_pending_then_clear();
    logic [63:0] exp_sum;
    beat(CFG_DATA, 32'h0000_0077);
    pulse_clear();
    wait_done("pend_clear");
    total++;
    if (ifc.wr_count !== 16'd0 || ifc.checksum !== 64'd0) begin
      bad++;
      $display("FAIL clear_zeroes got=%0d/%h want=0/0", ifc.wr_count, ifc.checksum);
    end
    beat(CFG_DATA, 32'h0000_0005);
    beat(CFG_DATA, 32'h0000_0006);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_addr !== 13'h0000 || ifc.wr_data !== 64'h0000_0006_0000_0005 || ifc.wr_count !== 16'd1) begin
      bad++;
      $display("FAIL post_clear_write got=%b/%h/%h/%0d want=1/0000/0000_0006_0000_0005/1", ifc.wr_en, ifc.wr_addr, ifc.wr_data, ifc.wr_count);
    end
`ifdef FF_LOADER_CHECKSUM_EN
    exp_sum = 64'h0000_0006_0000_0005;
`else
    exp_sum = 64'd0;
`endif
    total++;
    if (ifc.checksum !== exp_sum) begin
      bad++;
      $display("FAIL post_clear_checksum got=%h want=%h", ifc.checksum, exp_sum);
    end
  endtask

  task automatic test_checksum();
    logic [63:0] exp_sum;
    do_reset();
    beat(CFG_ADDR, 32'h0);
    beat(CFG_DATA, 32'h1);
    beat(CFG_DATA, 32'h0);
    total++;
    if (ifc.wr_en !== 1'b1 || ifc.wr_data !== 64'h1) begin
      bad++;
      $display("FAIL csum_write1 got=%b/%h want=1/1", ifc.wr_en, ifc.wr_data);
    end
    beat(CFG_DATA, 32'h2);
    beat(CFG_DATA, 32'h0);
`ifdef FF_LOADER_CHECKSUM_EN
    exp_sum = 64'h3;
`else
    exp_sum = 64'h0;
`endif
    total++;
    if (ifc.checksum !== exp_sum || ifc.wr_addr !== 13'h1) begin
      bad++;
      $display("FAIL checksum got=%h/%h want=%h/0001", ifc.checksum, ifc.wr_addr, exp_sum);
    end
  endtask

  task automatic test_reset_mid_clear();
    int errs = 0;
    pulse_clear();
    repeat (13'h400) step();
    total++;
    if (ifc.wr_addr !== 13'h0400 || ifc.busy !== 1'b1) begin
      bad++;
      $display("FAIL midclr_reach got=%h/%b want=0400/1", ifc.wr_addr, ifc.busy);
    end
    rst = 1'b1;
    step();
    total++;
    if ({ifc.wr_en, ifc.busy, ifc.done} !== 3'b000) begin
      bad++;
      $display("FAIL midclr_abort got=%b want=000", {ifc.wr_en, ifc.busy, ifc.done});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ifc.done !== 1'b0 || ifc.wr_en !== 1'b0 || ifc.cfg_ready !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL midclr_quiet got=%0d bad cycles want=0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_basic_write();
    test_wrap();
    test_stale_half();
    test_pending_then_clear();
    test_checksum();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
